// File: rtl/fifo_rd_pkg.sv
// Gray/binary pointer conversion helpers shared by the FIFO read- and write-side controllers.
// Functions work on a 32-bit container; callers zero-extend and truncate to their pointer width.
package fifo_rd_pkg;

  localparam int unsigned MaxPtrW = 32;

  function automatic logic [MaxPtrW-1:0] bin2gray(input logic [MaxPtrW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Each binary bit is the XOR of its Gray bit and every Gray bit above it.
  function automatic logic [MaxPtrW-1:0] gray2bin(input logic [MaxPtrW-1:0] g);
    logic [MaxPtrW-1:0] b;
    b = g;
    for (int i = 1; i < MaxPtrW; i++) begin
      b = b ^ (g >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/ptr_sync.sv
// Multi-flop synchroniser chain for Gray pointers crossing clock domains.
// Synchronous active-high reset clears every stage.
module ptr_sync #(
  parameter int unsigned WIDTH  = 11,
  parameter int unsigned STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_sync [STAGES];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < STAGES; i++) begin
        r_sync[i] <= '0;
      end
    end else begin
      r_sync[0] <= i_d;
      for (int unsigned i = 1; i < STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/rptr_empty_ctrl.sv
// Async FIFO read-side controller: read pointers, RAM address, empty/almost-empty/level flags.
// Optional sticky underflow flag built only when RPTR_UNDERFLOW_EN is defined.
module rptr_empty_ctrl
  import fifo_rd_pkg::*;
#(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned AEMPTY_TH   = 4
) (
  input  logic              rclk,
  input  logic              rrst,
  input  logic              ren,
  input  logic [ADDR_W:0]   wptr_g,
  output logic [ADDR_W-1:0] raddr,
  output logic [ADDR_W:0]   rptr_g,
  output logic              rempty,
  output logic              raempty,
  output logic [ADDR_W:0]   rlevel,
  output logic              runderflow
);

  localparam int unsigned PtrW = ADDR_W + 1;

  logic [ADDR_W:0]   w_wq_g;
  logic [ADDR_W:0]   w_rbin_next;
  logic [ADDR_W:0]   w_rgray_next;
  logic [ADDR_W:0]   w_wbin;
  logic [ADDR_W:0]   w_level;
  logic              w_pop;

  logic [ADDR_W:0]   r_rbin;
  logic [ADDR_W-1:0] r_raddr;
  logic [ADDR_W:0]   r_rptr_g;
  logic              r_rempty;
  logic              r_raempty;
  logic [ADDR_W:0]   r_rlevel;

  ptr_sync #(
    .WIDTH  (PtrW),
    .STAGES (SYNC_STAGES)
  ) u_wptr_sync (
    .i_clk (rclk),
    .i_rst (rrst),
    .i_d   (wptr_g),
    .o_q   (w_wq_g)
  );

  always_comb begin
    w_pop        = ren & ~r_rempty;
    w_rbin_next  = r_rbin + PtrW'(w_pop);
    w_rgray_next = PtrW'(bin2gray(32'(w_rbin_next)));
    w_wbin       = PtrW'(gray2bin(32'(w_wq_g)));
    w_level      = w_wbin - w_rbin_next;
  end

  // Full-width Gray compare: the wrap bit keeps a full FIFO from looking empty.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      r_rbin    <= '0;
      r_raddr   <= '0;
      r_rptr_g  <= '0;
      r_rempty  <= 1'b1;
      r_raempty <= 1'b1;
      r_rlevel  <= '0;
    end else begin
      r_rbin    <= w_rbin_next;
      r_raddr   <= w_rbin_next[ADDR_W-1:0];
      r_rptr_g  <= w_rgray_next;
      r_rempty  <= (w_rgray_next == w_wq_g);
      r_raempty <= (w_level <= PtrW'(AEMPTY_TH));
      r_rlevel  <= w_level;
    end
  end

  assign raddr   = r_raddr;
  assign rptr_g  = r_rptr_g;
  assign rempty  = r_rempty;
  assign raempty = r_raempty;
  assign rlevel  = r_rlevel;

`ifdef RPTR_UNDERFLOW_EN
  logic r_runderflow;

  always_ff @(posedge rclk) begin
    if (rrst) begin
      r_runderflow <= 1'b0;
    end else if (ren && r_rempty) begin
      r_runderflow <= 1'b1;
    end
  end

  assign runderflow = r_runderflow;
`else
  assign runderflow = 1'b0;
`endif

endmodule
